// File: rtl/shift_word_receiver.sv
// Serial-in, parallel-out receiver: frames MSB-first bits into WIDTH-bit words on a sync marker
// and presents them through a one-word valid/ready holding buffer with sticky error flags.
module shift_word_receiver #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             busy_q;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             frame_evt;
  logic             overrun_evt;

  assign shifted = {sreg_q[WIDTH-2:0], sin};

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    complete  = 1'b0;
    frame_evt = 1'b0;
    if (sin_valid) begin
      case (state_q)
        IDLE: begin
          // Unframed bits are dropped silently while waiting for sync.
          if (sync) begin
            sreg_d  = shifted;
            cnt_d   = CntW'(1);
            state_d = COLLECT;
          end
        end
        default: begin
          sreg_d = shifted;
          if (sync) begin
            frame_evt = 1'b1;
            cnt_d     = CntW'(1);
          end else if (cnt_q == CntW'(WIDTH - 1)) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    q_d         = q_q;
    q_valid_d   = q_valid_q;
    overrun_evt = 1'b0;
    if (complete) begin
      if (!q_valid_q || q_ready) begin
        q_d       = shifted;
        q_valid_d = 1'b1;
      end else begin
        overrun_evt = 1'b1;
      end
    end else if (q_valid_q && q_ready) begin
      q_valid_d = 1'b0;
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  assign overrun_d   = (overrun_q & ~clr_err) | overrun_evt;
  assign frame_err_d = (frame_err_q & ~clr_err) | frame_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      busy_q      <= (state_d == COLLECT);
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign q         = q_q;
  assign q_valid   = q_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_shift_word_receiver.sv
// Directed bench for shift_word_receiver: expected words are queued by the stimulus and
// popped by a monitor at each accepted handshake; flags and holding behaviour are checked inline.
module tb_shift_word_receiver;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready = 1'b0;
  logic         busy;
  logic         overrun;
  logic         frame_err;
  logic         clr_err = 1'b0;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass = 0;

  shift_word_receiver #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sync      (sync),
    .q         (q),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive one bit for one clock; inputs change 1 time unit after the rising edge.
  task automatic send_bit(input logic b, input logic s);
    sin       = b;
    sync      = s;
    sin_valid = 1'b1;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], i == W - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: a word is consumed at the next edge whenever q_valid & q_ready hold mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && q_valid && q_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL word_unexpected: got %0h, expected no word", q);
        end else begin
          check("word", 32'(q), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2;
    check("rst_q", 32'(q), 0);
    check("rst_q_valid", 32'(q_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_flags", {30'b0, overrun, frame_err}, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic word
    q_ready = 1'b1;
    exp_q.push_back(4'b1101);
    send_bit(1'b1, 1'b1);
    check("basic_busy", 32'(busy), 1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("basic_busy_c4", 32'(busy), 1);
    send_bit(1'b1, 1'b0);
    check("basic_q", 32'(q), 32'(4'b1101));
    check("basic_q_valid", 32'(q_valid), 1);
    check("basic_busy_done", 32'(busy), 0);
    check("basic_flags", {30'b0, overrun, frame_err}, 0);

    // Gapped bits
    exp_q.push_back(4'b0110);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    idle(2);
    check("gap_busy", 32'(busy), 1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("gap_q", 32'(q), 32'(4'b0110));
    idle(1);

    // Overrun
    q_ready = 1'b0;
    exp_q.push_back(4'b1010);
    send_word(4'b1010);
    send_word(4'b0011);
    check("ovr_q_held", 32'(q), 32'(4'b1010));
    check("ovr_q_valid", 32'(q_valid), 1);
    check("ovr_flag", 32'(overrun), 1);
    q_ready = 1'b1;
    idle(1);
    q_ready = 1'b0;
    check("ovr_drained", 32'(q_valid), 0);
    check("ovr_sticky", 32'(overrun), 1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("ovr_cleared", 32'(overrun), 0);

    // Accept and complete on the same edge
    exp_q.push_back(4'b1111);
    send_word(4'b1111);
    exp_q.push_back(4'b0001);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    q_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    q_ready = 1'b0;
    check("sim_q", 32'(q), 32'(4'b0001));
    check("sim_q_valid", 32'(q_valid), 1);
    check("sim_overrun", 32'(overrun), 0);

    // Early sync
    q_ready = 1'b1;
    exp_q.push_back(4'b1001);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    check("early_busy", 32'(busy), 1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("early_frame_err", 32'(frame_err), 1);
    check("early_q", 32'(q), 32'(4'b1001));
    idle(1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("early_cleared", 32'(frame_err), 0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    clr_err = 1'b1;
    send_bit(1'b1, 1'b1);
    clr_err = 1'b0;
    check("early_set_wins", 32'(frame_err), 1);

    // Reset mid-word with a held word and flag pending; the held word is lost.
    q_ready = 1'b0;
    send_word(4'b0101);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    check("pre_rst_busy", 32'(busy), 1);
    check("pre_rst_q_valid", 32'(q_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_q", 32'(q), 0);
    check("mid_rst_q_valid", 32'(q_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_flags", {30'b0, overrun, frame_err}, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    q_ready = 1'b1;
    exp_q.push_back(4'b0111);
    send_word(4'b0111);
    check("post_rst_q", 32'(q), 32'(4'b0111));
    check("post_rst_q_valid", 32'(q_valid), 1);
    idle(3);
    check("all_words_seen", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, expected finish before 20000");
    $fatal(1);
  end

endmodule
